// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkg
// Purpose  : Shared types and constants for the USB CRC transmit path:
//            transmitter state encoding and CRC-16/USB parameters
//            (reflected polynomial, initial value).
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_CRC1  = 3'd2,
    ST_CRC2  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // 0x8005 bit-reversed, for LSB-first shifting
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage : usb_pkg
`default_nettype wire

// File: rtl/usb_crc16_byte.sv
`default_nettype none
// ============================================================================
// Module   : usb_crc16_byte
// Purpose  : Combinational CRC-16/USB update by one byte, LSB first.
// Ports    : crc_in  [15:0] current CRC register
//            data    [7:0]  byte to fold in
//            crc_out [15:0] CRC register after the byte
// Revision : 1.0 - initial release
// ============================================================================
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_out = crc_step(crc_in, data);
  end

endmodule : usb_crc16_byte
`default_nettype wire

// File: rtl/usb_crc_tx.sv
`default_nettype none
// ============================================================================
// Module   : usb_crc_tx
// Purpose  : Forwards a payload byte stream to the PHY one cycle after
//            acceptance, then appends the inverted CRC-16/USB (low byte
//            first). Supports zero-length packets and a MAX_LEN overflow
//            guard that terminates the packet and raises a sticky len_err.
// Ports    : clk, reset (sync, active-low)
//            send_data, zlp                       - start request (IDLE only)
//            in_data/in_valid/in_last/in_ready    - payload stream
//            tx_data/tx_valid/tx_ready            - PHY byte output
//            busy, done, len_err                  - status
//            hist [HIST_DEPTH-1:0]                - tx_valid history, bit 0 newest
// Config   : USB_CRC_TX_HIST_EN - when defined, hist is a live shift register;
//            otherwise hist is tied to zero and no flops are built.
// Revision : 1.0 - initial release
// ============================================================================
module usb_crc_tx
  import usb_pkg::*;
#(
  parameter int HIST_DEPTH = 10,
  parameter int MAX_LEN    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_data,
  input  logic                  zlp,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [HIST_DEPTH-1:0] hist
);

  localparam int               CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        slot_free;
  logic        accept;
  logic [15:0] crc_upd;

  // The output slot can take a new byte when empty or being consumed now.
  assign slot_free = !tx_valid_q || tx_ready;
  assign in_ready  = (state_q == ST_DATA) && slot_free;
  assign accept    = in_valid && in_ready;

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (in_data),
    .crc_out (crc_upd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      crc_q      <= CRC16_INIT;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    // A presented byte stays until the PHY takes it.
    tx_valid_d = tx_valid_q && !tx_ready;
    done_d     = 1'b0;
    len_err_d  = len_err_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        if (send_data) begin
          len_err_d = 1'b0;
          crc_d     = CRC16_INIT;
          cnt_d     = '0;
          state_d   = zlp ? ST_CRC1 : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          tx_data_d  = in_data;
          tx_valid_d = 1'b1;
          crc_d      = crc_upd;
          cnt_d      = cnt_q + CNT_W'(1);
          if (in_last) begin
            state_d = ST_CRC1;
          end else if (cnt_q == LAST_IDX) begin
            // Byte MAX_LEN arrived without in_last: close the packet anyway.
            state_d   = ST_CRC1;
            len_err_d = 1'b1;
          end
        end
      end
      ST_CRC1: begin
        if (slot_free) begin
          tx_data_d  = ~crc_q[7:0];
          tx_valid_d = 1'b1;
          state_d    = ST_CRC2;
        end
      end
      ST_CRC2: begin
        if (slot_free) begin
          tx_data_d  = ~crc_q[15:8];
          tx_valid_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign len_err  = len_err_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef USB_CRC_TX_HIST_EN
  logic [HIST_DEPTH-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[HIST_DEPTH-2:0], tx_valid_q};
    end
  end

  assign hist = hist_q;
`else
  assign hist = '0;
`endif

endmodule : usb_crc_tx
`default_nettype wire

// File: tb/tb_usb_crc_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_crc_tx
// Purpose  : Directed self-checking bench for usb_crc_tx. Instance A uses the
//            default parameters; instance B uses MAX_LEN=4 for the overflow
//            case. Inputs other than send_data are shared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_crc_tx;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       send_a    = 1'b0;
  logic       send_b    = 1'b0;
  logic       zlp       = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       in_last   = 1'b0;
  logic       tx_ready  = 1'b1;
  logic       rnd       = 1'b0;

  logic       in_ready_a, tx_valid_a, busy_a, done_a, len_err_a;
  logic [7:0] tx_data_a;
  logic [9:0] hist_a;
  logic       in_ready_b, tx_valid_b, busy_b, done_b, len_err_b;
  logic [7:0] tx_data_b;
  logic [9:0] hist_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] stim[$];
  logic [7:0] expq[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;

  usb_crc_tx u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_a),
    .zlp       (zlp),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_a),
    .tx_data   (tx_data_a),
    .tx_valid  (tx_valid_a),
    .tx_ready  (tx_ready),
    .busy      (busy_a),
    .done      (done_a),
    .len_err   (len_err_a),
    .hist      (hist_a)
  );

  usb_crc_tx #(.HIST_DEPTH(10), .MAX_LEN(4)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_b),
    .zlp       (zlp),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_b),
    .tx_data   (tx_data_b),
    .tx_valid  (tx_valid_b),
    .tx_ready  (tx_ready),
    .busy      (busy_b),
    .done      (done_b),
    .len_err   (len_err_b),
    .hist      (hist_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PHY side: tx_ready either always high or a per-cycle coin flip.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte capture and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev)
        chk("stall_hold", {23'd0, tx_valid_a, tx_data_a}, {23'd0, 1'b1, stall_data});
      if (tx_valid_a && tx_ready) qa.push_back(tx_data_a);
      if (tx_valid_b && tx_ready) qb.push_back(tx_data_b);
      stall_prev = tx_valid_a && !tx_ready;
      stall_data = tx_data_a;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Bit-serial reference for CRC-16/USB, returns the transmitted (inverted) value.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ stim[k][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic start(input logic sel, input logic z);
    if (sel) send_b = 1'b1; else send_a = 1'b1;
    zlp = z;
    @(posedge clk);
    #1;
    send_a = 1'b0;
    send_b = 1'b0;
    zlp    = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic last, input logic sel);
    logic ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? in_ready_b : in_ready_a;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input logic sel, output logic found, output logic busy_at,
                           output logic [9:0] hist_at);
    found   = 1'b0;
    busy_at = 1'b1;
    hist_at = '0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        found   = 1'b1;
        busy_at = sel ? busy_b : busy_a;
        hist_at = sel ? hist_b : hist_a;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_stim_a();
    for (int i = 0; i < stim.size(); i++) feed(stim[i], (i == stim.size() - 1), 1'b0);
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, qa.size(), expq.size());
    for (int i = 0; i < expq.size() && i < qa.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), qa[i], expq[i]);
  endtask

  task automatic load_digits();
    stim.delete();
    expq.delete();
    for (int i = 0; i < 9; i++) begin
      stim.push_back(8'h31 + 8'(i));
      expq.push_back(8'h31 + 8'(i));
    end
    expq.push_back(8'hC8);
    expq.push_back(8'hB4);
  endtask

  initial begin
    logic       found;
    logic       bsy;
    logic [9:0] h;
    logic       rdy_seen;
    logic [15:0] crc_exp;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid_a, 1'b0);
    chk("rst_tx_data",  tx_data_a,  8'h00);
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_busy",     busy_a,     1'b0);
    chk("rst_done",     done_a,     1'b0);
    chk("rst_len_err",  len_err_a,  1'b0);
    chk("rst_hist",     hist_a,     10'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Zero-length packet
    qa.delete();
    start(1'b0, 1'b1);
    wait_done(1'b0, found, bsy, h);
    expq.delete();
    expq.push_back(8'h00);
    expq.push_back(8'h00);
    cmp_seq("zlp");
    chk("zlp_done", found, 1'b1);
    chk("zlp_busy_after", bsy, 1'b0);

    // "123456789" at full rate
    load_digits();
    qa.delete();
    start(1'b0, 1'b0);
    send_stim_a();
    wait_done(1'b0, found, bsy, h);
    cmp_seq("full");
    chk("full_len_err", len_err_a, 1'b0);

    // Same payload with random PHY stalls
    qa.delete();
    rnd = 1'b1;
    start(1'b0, 1'b0);
    send_stim_a();
    wait_done(1'b0, found, bsy, h);
    rnd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_seq("rand");

    // MAX_LEN=4 overflow on instance B
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'h10 + 8'(i));
    crc_exp = crc_ref(4);
    qb.delete();
    start(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) feed(stim[i], 1'b0, 1'b1);
    in_data  = stim[4];
    in_valid = 1'b1;
    rdy_seen = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (in_ready_b) rdy_seen = 1'b1;
      if (done_b) found = 1'b1;
    end
    in_valid = 1'b0;
    chk("ovf_done", found, 1'b1);
    chk("ovf_in_ready_after4", rdy_seen, 1'b0);
    chk("ovf_len", qb.size(), 6);
    for (int i = 0; i < 4 && i < qb.size(); i++) chk($sformatf("ovf_b%0d", i), qb[i], stim[i]);
    if (qb.size() >= 6) begin
      chk("ovf_crc_lo", qb[4], crc_exp[7:0]);
      chk("ovf_crc_hi", qb[5], crc_exp[15:8]);
    end
    chk("ovf_len_err", len_err_b, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_len_err_sticky", len_err_b, 1'b1);
    @(posedge clk);
    #1;
    start(1'b1, 1'b1);
    @(negedge clk);
    chk("ovf_len_err_cleared", len_err_b, 1'b0);
    wait_done(1'b1, found, bsy, h);

    // Reset in the middle of a packet
    load_digits();
    qa.delete();
    start(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) feed(stim[i], 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx_valid", tx_valid_a, 1'b0);
    chk("mid_rst_tx_data",  tx_data_a,  8'h00);
    chk("mid_rst_in_ready", in_ready_a, 1'b0);
    chk("mid_rst_busy",     busy_a,     1'b0);
    chk("mid_rst_done",     done_a,     1'b0);
    chk("mid_rst_hist",     hist_a,     10'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy_a, 1'b0);
    chk("post_rst_tx_valid", tx_valid_a, 1'b0);
    @(posedge clk);
    #1;
    qa.delete();
    start(1'b0, 1'b0);
    send_stim_a();
    wait_done(1'b0, found, bsy, h);
    cmp_seq("after_rst");

    // History: 3-byte packet at full rate after a quiet period
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    stim.delete();
    stim.push_back(8'h61);
    stim.push_back(8'h62);
    stim.push_back(8'h63);
    start(1'b0, 1'b0);
    send_stim_a();
    wait_done(1'b0, found, bsy, h);
`ifdef USB_CRC_TX_HIST_EN
    chk("hist_five_ones", h, 10'b00000_11111);
`else
    chk("hist_zero", h, 10'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_usb_crc_tx
`default_nettype wire
